// File: rtl/mem_ctrl.sv
// Multicycle-CPU memory interface: registered request toward memory, Instr/MDR capture, Stall to the control FSM.
// Optional build macro MEM_TIMEOUT_EN aborts an unacknowledged access after 255 ACCESS cycles.
module mem_ctrl (
  input  logic        clk,
  input  logic        res,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] Instr,
  output logic [31:0] MDR,
  output logic        Stall,
  output logic        MemErr
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, irw_q, irw_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, instr_q, instr_d, mdr_q, mdr_d;
  logic [31:0] sel_addr_s;
  logic        start_s;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  // Next-state and datapath capture logic.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    irw_d      = irw_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    instr_d    = instr_q;
    mdr_d      = mdr_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    start_s    = MemRead | MemWrite;
    sel_addr_s = IorD ? ALUOut : PC;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          if (sel_addr_s[1:0] != 2'b00) begin
            // Misaligned: never reach the bus, just flag and release the FSM.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = sel_addr_s;
            wdata_d = WriteData;
            irw_d   = IRWrite;
            state_d = ACCESS;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (!we_q) begin
            mdr_d = mem_rdata;
            if (irw_q) begin
              instr_d = mem_rdata;
            end else begin
              instr_d = instr_q;
            end
          end else begin
            mdr_d = mdr_q;
          end
          req_d   = 1'b0;
          state_d = DONE;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == 8'd254) begin
          // This edge brings the count to 255: give up on the access.
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`else
        end else begin
          state_d = ACCESS;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      instr_q <= 32'd0;
      mdr_q   <= 32'd0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      irw_q   <= irw_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      mdr_q   <= mdr_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Stall is combinational so the control FSM freezes in the request cycle itself.
  always_comb begin
    if (res) begin
      Stall = 1'b0;
    end else begin
      Stall = ((state_q == IDLE) && (MemRead | MemWrite)) || (state_q == ACCESS);
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign Instr     = instr_q;
  assign MDR       = mdr_q;
  assign MemErr    = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed scoreboard bench for mem_ctrl: each access pushes its expected outcome, which is popped and checked at DONE.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        res, MemRead, MemWrite, IorD, IRWrite, mem_ack;
  logic [31:0] PC, ALUOut, WriteData, mem_rdata;
  logic        mem_req, mem_we, Stall, MemErr;
  logic [31:0] mem_addr, mem_wdata, Instr, MDR;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] mdr;
    logic [31:0] instr;
    logic        err;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_mdr, m_instr;
  logic        m_err;

  mem_ctrl dut (
    .clk(clk), .res(res), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .Instr(Instr), .MDR(MDR),
    .Stall(Stall), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ack_at: cycle index (request cycle = 0) carrying mem_ack; negative means never ack.
  task automatic access(input string tag, input logic rd, input logic wr, input logic iord,
                        input logic irw, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [31:0] rdata, input int ack_at);
    exp_t        e;
    logic [31:0] a, obs_addr, obs_wdata;
    logic        obs_we, done, stable;
    int          stalls, reqs;
    a = iord ? alu : pc;
    e.addr = a; e.we = wr; e.wdata = wd;
    if (a[1:0] != 2'b00) begin
      m_err = 1'b1; e.stalls = 1; e.reqs = 0;
    end else if (ack_at < 0) begin
      m_err = 1'b1; e.stalls = 256; e.reqs = 255;
    end else begin
      e.stalls = ack_at + 1; e.reqs = ack_at;
      if (!wr) begin
        m_mdr = rdata;
        if (irw) m_instr = rdata;
      end
    end
    e.mdr = m_mdr; e.instr = m_instr; e.err = m_err;
    sb.push_back(e);

    MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
    PC = pc; ALUOut = alu; WriteData = wd;
    stalls = 0; reqs = 0; done = 1'b0; stable = 1'b1;
    obs_addr = 32'd0; obs_wdata = 32'd0; obs_we = 1'b0;
    for (int c = 0; c < 1100 && !done; c++) begin
      mem_ack   = (c == ack_at);
      mem_rdata = (c == ack_at) ? rdata : $urandom;
      @(negedge clk);
      if (Stall) stalls++;
      if (mem_req) begin
        if (reqs > 0 && (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wdata))
          stable = 1'b0;
        reqs++;
        obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
      end
      if (c > 0 && !Stall) done = 1'b1;
      next_cycle();
    end
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;

    e = sb.pop_front();
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_stalls"}, stalls, e.stalls);
    check({tag, "_reqs"}, reqs, e.reqs);
    check({tag, "_mdr"}, MDR, e.mdr);
    check({tag, "_instr"}, Instr, e.instr);
    check({tag, "_err"}, {31'd0, MemErr}, {31'd0, e.err});
    if (e.reqs > 0) begin
      check({tag, "_stable"}, {31'd0, stable}, 32'd1);
      check({tag, "_addr"}, obs_addr, e.addr);
      check({tag, "_we"}, {31'd0, obs_we}, {31'd0, e.we});
      if (e.we) check({tag, "_wdata"}, obs_wdata, e.wdata);
    end
    @(negedge clk);
    check({tag, "_idle_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_idle_stall"}, {31'd0, Stall}, 32'd0);
    next_cycle();
  endtask

  initial begin
    res = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
    PC = 32'd0; ALUOut = 32'd0; WriteData = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    m_mdr = 32'd0; m_instr = 32'd0; m_err = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_mdr", MDR, 32'd0);
    check("rst_err", {31'd0, MemErr}, 32'd0);
    next_cycle();
    res = 1'b0; MemRead = 1'b0;
    next_cycle();

    access("fetch", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 32'h8C22_0004, 2);
    access("load", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
    access("store", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0048, 32'h0000_0200, 32'h1234_5678, 32'h5555_5555, 1);
    access("rdwr", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_004C, 32'h0000_0204, 32'hA5A5_A5A5, 32'h1111_1111, 1);

    // Stray ack while idle must not load anything.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_mdr", MDR, m_mdr);
    check("idle_ack_instr", Instr, m_instr);
    check("idle_ack_req", {31'd0, mem_req}, 32'd0);
    next_cycle();

`ifdef MEM_TIMEOUT_EN
    access("timeout", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0050, 32'h0, 32'h0, 32'h7777_7777, -1);
`else
    access("noack", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0050, 32'h0, 32'h0, 32'h7777_7777, 1000);
`endif

    access("misalign", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0054, 32'h0000_0103, 32'h0, 32'h3333_3333, 1);
    access("sticky", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 32'h0, 32'h2001_0005, 1);

    // Reset in the middle of an access, then a late ack.
    MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; PC = 32'h0000_0080;
    next_cycle();
    @(negedge clk);
    check("mid_req", {31'd0, mem_req}, 32'd1);
    res = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, Stall}, 32'd0);
    next_cycle();
    res = 1'b0; MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_instr", Instr, 32'd0);
    check("mid_rst_mdr", MDR, 32'd0);
    check("mid_rst_err", {31'd0, MemErr}, 32'd0);
    check("mid_rst_stall2", {31'd0, Stall}, 32'd0);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_mdr", MDR, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    next_cycle();
    m_mdr = 32'd0; m_instr = 32'd0; m_err = 1'b0;
    access("post_rst", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0084, 32'h0, 32'h0, 32'h0BAD_C0DE, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
